// File: rtl/alu_req_master.sv
`default_nettype none
// ============================================================================
// Module  : alu_req_master
// Brief   : Buffers ALU commands, issues them over valid/ready, tags returns
//           with their opcode and presents results downstream.
//           Optional macro ALU_REQ_MASTER_STATS_EN adds issue/done/stall counters.
// Revision: 1.0 - initial release
// ============================================================================
module alu_req_master #(
  parameter int WIDTH     = 8,
  parameter int OUT_WIDTH = WIDTH + 3,
  parameter int CMD_DEPTH = 4,
  parameter int MAX_OUTST = 4
) (
  input  logic                 i_CLK,
  input  logic                 i_RST,
  input  logic                 i_cmd_valid,
  output logic                 o_cmd_ready,
  input  logic [WIDTH-1:0]     i_cmd_arg0,
  input  logic [WIDTH-1:0]     i_cmd_arg1,
  input  logic [1:0]           i_cmd_oper,
  input  logic                 i_flush,
  output logic [WIDTH-1:0]     o_alu_arg0,
  output logic [WIDTH-1:0]     o_alu_arg1,
  output logic [1:0]           o_alu_oper,
  output logic                 o_alu_VALID,
  input  logic                 i_alu_READY,
  input  logic                 i_alu_VALID,
  output logic                 o_alu_READY,
  input  logic [OUT_WIDTH-1:0] i_alu_Y,
  output logic                 o_res_valid,
  input  logic                 i_res_ready,
  output logic [OUT_WIDTH-1:0] o_res_Y,
  output logic [1:0]           o_res_oper,
  output logic [3:0]           o_outst,
  output logic                 o_busy
`ifdef ALU_REQ_MASTER_STATS_EN
  ,
  output logic [15:0]          o_stat_issued,
  output logic [15:0]          o_stat_done,
  output logic [15:0]          o_stat_stall
`endif
);

  localparam int          AW          = $clog2(CMD_DEPTH);
  localparam logic [AW-1:0] C_PTR_ONE = AW'(1);
  localparam logic [AW:0]   C_CNT_ONE = (AW+1)'(1);
  localparam logic [AW:0]   C_CMD_FULL = (AW+1)'(CMD_DEPTH);
  localparam logic [3:0]  C_MAX_OUTST = 4'(MAX_OUTST);
  localparam logic [3:0]  C_TAG_LAST  = 4'(MAX_OUTST - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

  state_t               r_state;
  logic [WIDTH-1:0]     r_arg0_mem [CMD_DEPTH];
  logic [WIDTH-1:0]     r_arg1_mem [CMD_DEPTH];
  logic [1:0]           r_oper_mem [CMD_DEPTH];
  logic [AW-1:0]        r_wr_ptr;
  logic [AW-1:0]        r_rd_ptr;
  logic [AW:0]          r_cmd_cnt;
  logic [1:0]           r_tag_mem  [16];
  logic [3:0]           r_tag_wr;
  logic [3:0]           r_tag_rd;
  logic [3:0]           r_outst;
  logic                 r_res_valid;
  logic [OUT_WIDTH-1:0] r_res_y;
  logic [1:0]           r_res_oper;

  logic       w_empty;
  logic       w_full;
  logic       w_push;
  logic       w_issue;
  logic       w_ret;
  logic [3:0] w_tag_wr_nxt;
  logic [3:0] w_tag_rd_nxt;

  assign w_empty = (r_cmd_cnt == '0);
  assign w_full  = (r_cmd_cnt == C_CMD_FULL);

  assign o_cmd_ready = !i_RST && !w_full && (r_state != S_FLUSH);
  // Issue is allowed in FLUSH as well so buffered commands drain out.
  assign o_alu_VALID = !w_empty && (r_outst < C_MAX_OUTST) && (r_state != S_IDLE);
  assign o_alu_arg0  = w_empty ? '0 : r_arg0_mem[r_rd_ptr];
  assign o_alu_arg1  = w_empty ? '0 : r_arg1_mem[r_rd_ptr];
  assign o_alu_oper  = w_empty ? '0 : r_oper_mem[r_rd_ptr];
  assign o_alu_READY = !r_res_valid || i_res_ready;

  assign w_push  = i_cmd_valid && o_cmd_ready;
  assign w_issue = o_alu_VALID && i_alu_READY;
  // A return with nothing in flight is a protocol error and is dropped.
  assign w_ret   = i_alu_VALID && o_alu_READY && (r_outst != 4'd0);

  assign w_tag_wr_nxt = (r_tag_wr == C_TAG_LAST) ? 4'd0 : r_tag_wr + 4'd1;
  assign w_tag_rd_nxt = (r_tag_rd == C_TAG_LAST) ? 4'd0 : r_tag_rd + 4'd1;

  assign o_res_valid = r_res_valid;
  assign o_res_Y     = r_res_y;
  assign o_res_oper  = r_res_oper;
  assign o_outst     = r_outst;
  assign o_busy      = (r_state != S_IDLE) || !w_empty || (r_outst != 4'd0) || r_res_valid;

  always_ff @(posedge i_CLK) begin
    if (w_push) begin
      r_arg0_mem[r_wr_ptr] <= i_cmd_arg0;
      r_arg1_mem[r_wr_ptr] <= i_cmd_arg1;
      r_oper_mem[r_wr_ptr] <= i_cmd_oper;
    end
    if (w_issue) begin
      r_tag_mem[r_tag_wr] <= r_oper_mem[r_rd_ptr];
    end
  end

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      r_state     <= S_IDLE;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_cmd_cnt   <= '0;
      r_tag_wr    <= '0;
      r_tag_rd    <= '0;
      r_outst     <= '0;
      r_res_valid <= 1'b0;
      r_res_y     <= '0;
      r_res_oper  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
      if (w_issue) begin
        r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
        r_tag_wr <= w_tag_wr_nxt;
      end
      case ({w_push, w_issue})
        2'b10:   r_cmd_cnt <= r_cmd_cnt + C_CNT_ONE;
        2'b01:   r_cmd_cnt <= r_cmd_cnt - C_CNT_ONE;
        default: ;
      endcase
      case ({w_issue, w_ret})
        2'b10:   r_outst <= r_outst + 4'd1;
        2'b01:   r_outst <= r_outst - 4'd1;
        default: ;
      endcase
      if (w_ret) begin
        r_res_valid <= 1'b1;
        r_res_y     <= i_alu_Y;
        r_res_oper  <= r_tag_mem[r_tag_rd];
        r_tag_rd    <= w_tag_rd_nxt;
      end else if (i_res_ready) begin
        r_res_valid <= 1'b0;
      end
      case (r_state)
        // Looking at the push lets a fresh command issue on the next cycle.
        S_IDLE:  if (!w_empty || w_push) r_state <= S_RUN;
        S_RUN: begin
          if (i_flush) r_state <= S_FLUSH;
          else if (w_empty && !w_push && (r_outst == 4'd0)) r_state <= S_IDLE;
        end
        S_FLUSH: if (w_empty && (r_outst == 4'd0) && !r_res_valid) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef ALU_REQ_MASTER_STATS_EN
  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      o_stat_issued <= '0;
      o_stat_done   <= '0;
      o_stat_stall  <= '0;
    end else begin
      if (w_issue && (o_stat_issued != 16'hFFFF)) o_stat_issued <= o_stat_issued + 16'd1;
      if (w_ret && (o_stat_done != 16'hFFFF)) o_stat_done <= o_stat_done + 16'd1;
      if (o_alu_VALID && !i_alu_READY && (o_stat_stall != 16'hFFFF))
        o_stat_stall <= o_stat_stall + 16'd1;
    end
  end
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_req_master.sv
`default_nettype none
// Randomised and directed bench for alu_req_master with a queue-based
// reference model and a behavioural ALU responder.
module tb_alu_req_master;
  localparam int WIDTH = 8, OUT_WIDTH = 11, CMD_DEPTH = 4, MAX_OUTST = 4;

  logic                 i_CLK = 1'b0;
  logic                 i_RST, i_cmd_valid, i_flush, i_alu_READY, i_alu_VALID, i_res_ready;
  logic [WIDTH-1:0]     i_cmd_arg0, i_cmd_arg1;
  logic [1:0]           i_cmd_oper;
  logic [OUT_WIDTH-1:0] i_alu_Y;
  logic                 o_cmd_ready, o_alu_VALID, o_alu_READY, o_res_valid, o_busy;
  logic [WIDTH-1:0]     o_alu_arg0, o_alu_arg1;
  logic [1:0]           o_alu_oper, o_res_oper;
  logic [OUT_WIDTH-1:0] o_res_Y;
  logic [3:0]           o_outst;
`ifdef ALU_REQ_MASTER_STATS_EN
  logic [15:0]          o_stat_issued, o_stat_done, o_stat_stall;
`endif

  always #5 i_CLK = ~i_CLK;

  alu_req_master #(.WIDTH(WIDTH), .OUT_WIDTH(OUT_WIDTH), .CMD_DEPTH(CMD_DEPTH),
                   .MAX_OUTST(MAX_OUTST)) dut (
    .i_CLK(i_CLK), .i_RST(i_RST), .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
    .i_cmd_arg0(i_cmd_arg0), .i_cmd_arg1(i_cmd_arg1), .i_cmd_oper(i_cmd_oper),
    .i_flush(i_flush), .o_alu_arg0(o_alu_arg0), .o_alu_arg1(o_alu_arg1),
    .o_alu_oper(o_alu_oper), .o_alu_VALID(o_alu_VALID), .i_alu_READY(i_alu_READY),
    .i_alu_VALID(i_alu_VALID), .o_alu_READY(o_alu_READY), .i_alu_Y(i_alu_Y),
    .o_res_valid(o_res_valid), .i_res_ready(i_res_ready), .o_res_Y(o_res_Y),
    .o_res_oper(o_res_oper), .o_outst(o_outst), .o_busy(o_busy)
`ifdef ALU_REQ_MASTER_STATS_EN
    , .o_stat_issued(o_stat_issued), .o_stat_done(o_stat_done), .o_stat_stall(o_stat_stall)
`endif
  );

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [1:0] op;
  } cmd_t;

  // Reference model: accepted-not-issued, issued-not-returned, result slot.
  cmd_t           cmd_q[$];
  cmd_t           inflight[$];
  cmd_t           slot;
  bit             slot_v = 0;
  bit             flush_mode = 0;
  logic [10:0]    alu_y_q[$];
  logic [10:0]    deliv_y[$];
  logic [1:0]     deliv_op[$];
  int             checks = 0, errors = 0, pushed = 0;
  int             rdy_pct = 100, ret_pct = 100, rres_pct = 100;
  bit             cmd_auto = 0;

  function automatic logic [10:0] alu_fn(logic [7:0] a, logic [7:0] b, logic [1:0] op);
    case (op)
      2'd0:    return 11'(a) + 11'(b);
      2'd1:    return 11'(a) - 11'(b);
      2'd2:    return 11'(a & b);
      default: return 11'(a ^ b);
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    bit          exp_rdy, exp_val, exp_ard, push, iss, ret, ret_ok, f_set, f_done, dlv;
    cmd_t        c;
    logic [10:0] ay;
    i_alu_READY = ($urandom_range(0, 99) < rdy_pct);
    i_res_ready = ($urandom_range(0, 99) < rres_pct);
    i_alu_VALID = (alu_y_q.size() > 0) && ($urandom_range(0, 99) < ret_pct);
    i_alu_Y     = (alu_y_q.size() > 0) ? alu_y_q[0] : 11'h0;
    if (cmd_auto) begin
      i_cmd_valid = ($urandom_range(0, 99) < 50);
      i_cmd_arg0  = 8'($urandom);
      i_cmd_arg1  = 8'($urandom);
      i_cmd_oper  = 2'($urandom);
      i_flush     = (cmd_q.size() > 0) && ($urandom_range(0, 99) < 2);
    end
    #2;
    exp_rdy = !i_RST && (cmd_q.size() < CMD_DEPTH) && !flush_mode;
    exp_val = (cmd_q.size() > 0) && (inflight.size() < MAX_OUTST);
    exp_ard = !slot_v || i_res_ready;
    chk("cmd_ready", o_cmd_ready, exp_rdy);
    chk("alu_valid", o_alu_VALID, exp_val);
    if (exp_val) begin
      c = cmd_q[0];
      chk("alu_arg0", o_alu_arg0, c.a);
      chk("alu_arg1", o_alu_arg1, c.b);
      chk("alu_oper", o_alu_oper, c.op);
    end
    chk("alu_ready", o_alu_READY, exp_ard);
    chk("res_valid", o_res_valid, slot_v);
    if (slot_v) begin
      chk("res_y", o_res_Y, alu_fn(slot.a, slot.b, slot.op));
      chk("res_oper", o_res_oper, slot.op);
    end
    chk("outst", o_outst, inflight.size());
    push   = i_cmd_valid && exp_rdy;
    iss    = exp_val && i_alu_READY;
    ret    = i_alu_VALID && exp_ard;
    ret_ok = ret && (inflight.size() > 0);
    dlv    = slot_v && i_res_ready && !i_RST;
    f_set  = i_flush && (cmd_q.size() > 0);
    f_done = flush_mode && (cmd_q.size() == 0) && (inflight.size() == 0) && !slot_v;
    ay     = alu_fn(o_alu_arg0, o_alu_arg1, o_alu_oper);
    c      = '{a: i_cmd_arg0, b: i_cmd_arg1, op: i_cmd_oper};
    if (dlv) begin
      deliv_y.push_back(o_res_Y);
      deliv_op.push_back(o_res_oper);
    end
    @(posedge i_CLK);
    #1;
    if (ret) void'(alu_y_q.pop_front());
    if (iss) alu_y_q.push_back(ay);
    if (i_RST) begin
      cmd_q.delete();
      inflight.delete();
      slot_v     = 0;
      flush_mode = 0;
    end else begin
      if (ret_ok) begin
        slot   = inflight.pop_front();
        slot_v = 1;
      end else if (i_res_ready) begin
        slot_v = 0;
      end
      if (iss) inflight.push_back(cmd_q.pop_front());
      if (push) begin
        cmd_q.push_back(c);
        pushed++;
      end
      if (f_set) flush_mode = 1;
      else if (f_done) flush_mode = 0;
    end
  endtask

  task automatic push_cmd(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op);
    i_cmd_valid = 1'b1;
    i_cmd_arg0  = a;
    i_cmd_arg1  = b;
    i_cmd_oper  = op;
    step();
    i_cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    cmd_auto = 0; i_cmd_valid = 0; i_flush = 0;
    rdy_pct = 100; ret_pct = 100; rres_pct = 100;
    while ((cmd_q.size() > 0 || inflight.size() > 0 || slot_v || flush_mode) && n < 200) begin
      step();
      n++;
    end
    chk("drain_bound", n < 200, 1'b1);
    repeat (2) step();
    chk("busy_idle", o_busy, 1'b0);
  endtask

  initial begin
    int n;
    i_RST = 1; i_cmd_valid = 0; i_flush = 0; i_alu_READY = 0; i_alu_VALID = 0;
    i_res_ready = 1; i_cmd_arg0 = 0; i_cmd_arg1 = 0; i_cmd_oper = 0; i_alu_Y = 0;
    @(posedge i_CLK);
    #1;
    step();
    chk("rst_cmd_ready", o_cmd_ready, 1'b0);
    chk("rst_alu_valid", o_alu_VALID, 1'b0);
    chk("rst_arg0", o_alu_arg0, 8'h0);
    chk("rst_oper", o_alu_oper, 2'h0);
    chk("rst_busy", o_busy, 1'b0);
    i_RST = 0;
    #1;
    chk("cmd_ready_after_rst", o_cmd_ready, 1'b1);

    // ADD 10+5
    push_cmd(8'd10, 8'd5, 2'd0);
    drain();
    chk("add_y", deliv_y[0], 11'd15);
    chk("add_oper", deliv_op[0], 2'd0);
    deliv_y.delete(); deliv_op.delete();

    // back-to-back ADD / SUB / AND
    push_cmd(8'd127, 8'd1, 2'd0);
    push_cmd(8'd50, 8'd50, 2'd1);
    push_cmd(8'hAA, 8'h0F, 2'd2);
    drain();
    chk("b2b_count", deliv_y.size(), 3);
    chk("b2b_y0", deliv_y[0], 11'd128);
    chk("b2b_y1", deliv_y[1], 11'd0);
    chk("b2b_y2", deliv_y[2], 11'h0A);
    chk("b2b_op1", deliv_op[1], 2'd1);
    chk("b2b_op2", deliv_op[2], 2'd2);
    deliv_y.delete(); deliv_op.delete();

    // ALU stalls: FIFO fills, fifth push refused, head held stable
    rdy_pct = 0;
    for (int i = 0; i < 4; i++) push_cmd(8'(8 * i + 1), 8'(i + 2), 2'(i));
    chk("full_cmd_ready", o_cmd_ready, 1'b0);
    push_cmd(8'hEE, 8'hEE, 2'd3);
    repeat (3) step();
    chk("stall_valid", o_alu_VALID, 1'b1);
    drain();
    chk("stall_count", deliv_y.size(), 4);
    deliv_y.delete(); deliv_op.delete();

    // downstream backpressure holds the result
    rres_pct = 0;
    push_cmd(8'd3, 8'd4, 2'd3);
    push_cmd(8'd9, 8'd2, 2'd1);
    n = 0;
    while (!slot_v && n < 20) begin step(); n++; end
    chk("bp_bound", n < 20, 1'b1);
    repeat (3) step();
    chk("bp_alu_ready", o_alu_READY, 1'b0);
    chk("bp_res_y", o_res_Y, 11'd7);
    drain();
    deliv_y.delete(); deliv_op.delete();

    // flush with commands buffered
    rdy_pct = 0;
    push_cmd(8'd20, 8'd7, 2'd1);
    push_cmd(8'd1, 8'd1, 2'd0);
    i_flush = 1;
    step();
    i_flush = 0;
    chk("flush_cmd_ready", o_cmd_ready, 1'b0);
    drain();
    chk("flush_count", deliv_y.size(), 2);
    deliv_y.delete(); deliv_op.delete();

    // reset with two requests in flight; stale returns must be dropped
    ret_pct = 0;
    push_cmd(8'd5, 8'd6, 2'd0);
    push_cmd(8'd7, 8'd8, 2'd2);
    n = 0;
    while (inflight.size() < 2 && n < 20) begin step(); n++; end
    chk("inflight_bound", n < 20, 1'b1);
    i_RST = 1;
    step();
    i_RST = 0;
    chk("rst2_res_valid", o_res_valid, 1'b0);
    chk("rst2_res_y", o_res_Y, 11'd0);
    chk("rst2_res_oper", o_res_oper, 2'd0);
    chk("rst2_outst", o_outst, 4'd0);
    chk("rst2_busy", o_busy, 1'b0);
    ret_pct = 100;
    repeat (4) step();
    chk("stale_res_valid", o_res_valid, 1'b0);
    chk("stale_outst", o_outst, 4'd0);
    alu_y_q.delete();
    deliv_y.delete(); deliv_op.delete();

    // randomised traffic
    pushed = 0;
    cmd_auto = 1; rdy_pct = 60; ret_pct = 60; rres_pct = 70;
    repeat (500) step();
    drain();
    chk("rand_count", deliv_y.size(), pushed);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
